// File: rtl/shift_reg_gated_elastic_lookup_pkg.sv
// shift_reg_gated_elastic_lookup_pkg: port-width helpers that keep Depth==0 ports non-empty
package shift_reg_gated_elastic_lookup_pkg;
   function automatic int unsigned cnt_width(input int unsigned depth);
      return (depth == 0) ? 1 : $clog2(depth + 1);
   endfunction
   function automatic int unsigned hit_width(input int unsigned depth);
      return (depth == 0) ? 1 : depth;
   endfunction
endpackage

// File: rtl/shift_reg_gated_elastic_lookup_if.sv
// shift_reg_gated_elastic_lookup_if: ready/valid descriptor stream carrying a lookup key and payload
interface shift_reg_gated_elastic_lookup_if #(
   parameter int unsigned KeyWidth = 32'd8,
   parameter type dtype = logic
);
   logic valid;
   logic ready;
   logic [KeyWidth-1:0] key;
   dtype data;
   modport master (output valid, key, data, input ready);
   modport slave (input valid, key, data, output ready);
endinterface

// File: rtl/shift_reg_gated_elastic_lookup_cmp.sv
// shift_reg_gated_elastic_lookup_cmp: parallel per-stage key comparators with OR-reduced hit
module shift_reg_gated_elastic_lookup_cmp #(
   parameter int unsigned Depth = 32'd4,
   parameter int unsigned KeyWidth = 32'd8
) (
   input logic [Depth-1:0] valid_i,
   input logic [Depth-1:0][KeyWidth-1:0] key_i,
   input logic [KeyWidth-1:0] lookup_key_i,
   output logic [Depth-1:0] hit_o,
   output logic any_o
);
   for (genvar i = 0; i < Depth; i++) begin : g_cmp
      assign hit_o[i] = valid_i[i] & (key_i[i] == lookup_key_i);
   end
   assign any_o = |hit_o;
endmodule

// File: rtl/shift_reg_gated_elastic_lookup.sv
// shift_reg_gated_elastic_lookup: elastic clock-gated shift register with flush, key lookup and occupancy count
module shift_reg_gated_elastic_lookup
   import shift_reg_gated_elastic_lookup_pkg::*;
#(
   parameter int unsigned Depth = 32'd4,
   parameter int unsigned KeyWidth = 32'd8,
   parameter type dtype = logic,
   localparam int unsigned CntWidth = cnt_width(Depth),
   localparam int unsigned HitWidth = hit_width(Depth)
) (
   input logic clk_i,
   input logic rst_ni,
   input logic flush_i,
   shift_reg_gated_elastic_lookup_if.slave in_s,
   shift_reg_gated_elastic_lookup_if.master out_m,
   input logic [KeyWidth-1:0] lookup_key_i,
   output logic [HitWidth-1:0] lookup_hit_o,
   output logic lookup_any_o,
   output logic [CntWidth-1:0] count_o
);
   if (Depth == 0) begin : g_pass
      assign out_m.valid = in_s.valid;
      assign out_m.key = in_s.key;
      assign out_m.data = in_s.data;
      assign in_s.ready = out_m.ready;
      assign lookup_hit_o = '0;
      assign lookup_any_o = 1'b0;
      assign count_o = '0;
   end else begin : g_reg
      logic advance;
      logic [Depth-1:0] valid_q, valid_d, valid_in;
      logic [Depth-1:0][KeyWidth-1:0] key_q, key_in;
      dtype data_q [Depth];
      dtype data_in [Depth];
      logic [CntWidth-1:0] cnt_d;
      assign advance = ~valid_q[Depth-1] | out_m.ready;
      assign in_s.ready = advance;
      always_comb begin
         valid_in[0] = in_s.valid;
         key_in[0] = in_s.key;
         data_in[0] = in_s.data;
         for (int i = 1; i < Depth; i++) begin
            valid_in[i] = valid_q[i-1];
            key_in[i] = key_q[i-1];
            data_in[i] = data_q[i-1];
         end
      end
      assign valid_d = flush_i ? '0 : advance ? valid_in : valid_q;
      always_comb begin
         cnt_d = '0;
         for (int i = 0; i < Depth; i++) cnt_d += CntWidth'(valid_d[i]);
      end
      // payload flops load only for valid entries so bubbles never toggle them
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            valid_q <= '0;
            count_o <= '0;
            for (int i = 0; i < Depth; i++) begin
               key_q[i] <= '0;
               data_q[i] <= '0;
            end
         end else begin
            valid_q <= valid_d;
            count_o <= cnt_d;
            for (int i = 0; i < Depth; i++) begin
               if (advance & valid_d[i]) begin
                  key_q[i] <= key_in[i];
                  data_q[i] <= data_in[i];
               end
            end
         end
      end
      assign out_m.valid = valid_q[Depth-1];
      assign out_m.key = key_q[Depth-1];
      assign out_m.data = data_q[Depth-1];
      shift_reg_gated_elastic_lookup_cmp #(.Depth(Depth), .KeyWidth(KeyWidth)) u_cmp (
         .valid_i(valid_q),
         .key_i(key_q),
         .lookup_key_i(lookup_key_i),
         .hit_o(lookup_hit_o),
         .any_o(lookup_any_o)
      );
   end
endmodule

// File: tb/tb_shift_reg_gated_elastic_lookup.sv
// tb_shift_reg_gated_elastic_lookup: vector table plus scoreboard bench for Depth=4 and Depth=0 instances
module tb_shift_reg_gated_elastic_lookup;
   typedef struct packed {
      logic v;
      logic [7:0] k;
      logic [7:0] lk;
      logic vo;
      logic [7:0] ko;
      logic [3:0] hit;
      logic any;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush, z_flush;
   logic [7:0] lookup_key, z_lookup_key;
   logic [3:0] hit;
   logic any, z_any;
   logic [2:0] count;
   logic [0:0] z_hit, z_count;
   int n_chk = 0;
   int n_fail = 0;
   logic [15:0] sb [$];
   vec_t tbl [9];
   always #5 clk = ~clk;
   shift_reg_gated_elastic_lookup_if #(.KeyWidth(8), .dtype(logic [7:0])) in_if (), out_if (), z_in_if (), z_out_if ();
   shift_reg_gated_elastic_lookup #(.Depth(4), .KeyWidth(8), .dtype(logic [7:0])) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_s(in_if.slave), .out_m(out_if.master),
      .lookup_key_i(lookup_key), .lookup_hit_o(hit), .lookup_any_o(any), .count_o(count)
   );
   shift_reg_gated_elastic_lookup #(.Depth(0), .KeyWidth(8), .dtype(logic [7:0])) dut_z (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(z_flush), .in_s(z_in_if.slave), .out_m(z_out_if.master),
      .lookup_key_i(z_lookup_key), .lookup_hit_o(z_hit), .lookup_any_o(z_any), .count_o(z_count)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask
   // drive one cycle, check occupancy and any output handshake, then book the input handshake
   task automatic step(input logic v, input logic [7:0] k, input logic r, input logic f, input logic [7:0] lk);
      logic [15:0] e;
      @(negedge clk);
      in_if.valid = v;
      in_if.key = k;
      in_if.data = k ^ 8'h5a;
      out_if.ready = r;
      flush = f;
      lookup_key = lk;
      #1;
      chk("count", 32'(count), sb.size());
      if (out_if.valid && r) begin
         e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
         chk("out_key", 32'(out_if.key), 32'(e[15:8]));
         chk("out_data", 32'(out_if.data), 32'(e[7:0]));
      end
      if (f) sb.delete();
      else if (v && in_if.ready) sb.push_back({k, k ^ 8'h5a});
   endtask
   initial begin
      tbl[0] = '{1'b1, 8'h01, 8'hff, 1'b0, 8'h00, 4'b0000, 1'b0};
      tbl[1] = '{1'b1, 8'h02, 8'h01, 1'b0, 8'h00, 4'b0001, 1'b1};
      tbl[2] = '{1'b1, 8'h03, 8'h02, 1'b0, 8'h00, 4'b0001, 1'b1};
      tbl[3] = '{1'b1, 8'h04, 8'h03, 1'b0, 8'h00, 4'b0001, 1'b1};
      tbl[4] = '{1'b0, 8'h00, 8'h02, 1'b1, 8'h01, 4'b0100, 1'b1};
      tbl[5] = '{1'b0, 8'h00, 8'h01, 1'b1, 8'h02, 4'b0000, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 8'h04, 1'b1, 8'h03, 4'b0100, 1'b1};
      tbl[7] = '{1'b0, 8'h00, 8'h04, 1'b1, 8'h04, 4'b1000, 1'b1};
      tbl[8] = '{1'b0, 8'h00, 8'h04, 1'b0, 8'h00, 4'b0000, 1'b0};
      in_if.valid = 1'b0;
      in_if.key = '0;
      in_if.data = '0;
      out_if.ready = 1'b0;
      flush = 1'b0;
      lookup_key = 8'h00;
      z_in_if.valid = 1'b0;
      z_in_if.key = '0;
      z_in_if.data = '0;
      z_out_if.ready = 1'b0;
      z_flush = 1'b0;
      z_lookup_key = '0;
      #1;
      chk("rst_valid_o", 32'(out_if.valid), 0);
      chk("rst_key_o", 32'(out_if.key), 0);
      chk("rst_data_o", 32'(out_if.data), 0);
      chk("rst_hit", 32'(hit), 0);
      chk("rst_any", 32'(any), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ready_o", 32'(in_if.ready), 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].v, tbl[i].k, 1'b1, 1'b0, tbl[i].lk);
         chk("t1_valid_o", 32'(out_if.valid), 32'(tbl[i].vo));
         if (tbl[i].vo) chk("t1_key_o", 32'(out_if.key), 32'(tbl[i].ko));
         chk("t1_ready_o", 32'(in_if.ready), 1);
         chk("t1_hit", 32'(hit), 32'(tbl[i].hit));
         chk("t1_any", 32'(any), 32'(tbl[i].any));
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, 8'hff);
         chk("bp_fill_ready", 32'(in_if.ready), 1);
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 8'h25, 1'b0, 1'b0, 8'hff);
         chk("bp_full_ready", 32'(in_if.ready), 0);
         chk("bp_hold_valid", 32'(out_if.valid), 1);
         chk("bp_hold_key", 32'(out_if.key), 32'h21);
         chk("bp_hold_data", 32'(out_if.data), 32'(8'h21 ^ 8'h5a));
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 8'hff);
         chk("bp_rel_ready", 32'(in_if.ready), 1);
         chk("bp_rel_valid", 32'(out_if.valid), 32'(i < 4));
         if (i < 4) chk("bp_rel_key", 32'(out_if.key), 32'(8'h21 + i));
      end
      step(1'b1, 8'h05, 1'b1, 1'b0, 8'hff);
      step(1'b1, 8'h07, 1'b1, 1'b0, 8'hff);
      step(1'b1, 8'h05, 1'b1, 1'b0, 8'hff);
      step(1'b0, 8'h00, 1'b1, 1'b0, 8'h05);
      chk("lk5_hit", 32'(hit), 32'b0101);
      chk("lk5_any", 32'(any), 1);
      lookup_key = 8'h09;
      #1;
      chk("lk9_hit", 32'(hit), 0);
      chk("lk9_any", 32'(any), 0);
      step(1'b1, 8'h66, 1'b1, 1'b1, 8'hff);
      chk("fl_ready", 32'(in_if.ready), 1);
      chk("fl_valid_o", 32'(out_if.valid), 1);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 8'hff);
         chk("fl_after_valid", 32'(out_if.valid), 0);
      end
      for (int t = 0; t < 10; t++) begin
         step(t < 5 && t % 2 == 0, (t < 5 && t % 2 == 0) ? 8'(8'ha1 + t) : 8'hbb, 1'b1, 1'b0, 8'hff);
         if (t >= 4) begin
            chk("alt_valid", 32'(out_if.valid), 32'(t % 2 == 0));
            chk("alt_key_held", 32'(out_if.key), 32'(8'ha1 + ((t - 4) & ~1)));
         end
      end
      chk("sb_drained", sb.size(), 0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 8'hff);
      chk("ar_pre_valid", 32'(out_if.valid), 1);
      in_if.valid = 1'b0;
      out_if.ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("ar_valid_o", 32'(out_if.valid), 0);
      chk("ar_count", 32'(count), 0);
      chk("ar_key_o", 32'(out_if.key), 0);
      chk("ar_ready_o", 32'(in_if.ready), 1);
      chk("ar_any", 32'(any), 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic v, r, f;
         logic [7:0] k, d, lk;
         {v, r, f, k, d, lk} = 27'($urandom);
         z_in_if.valid = v;
         z_in_if.key = k;
         z_in_if.data = d;
         z_out_if.ready = r;
         z_flush = f;
         z_lookup_key = lk;
         #1;
         chk("d0_valid", 32'(z_out_if.valid), 32'(v));
         chk("d0_ready", 32'(z_in_if.ready), 32'(r));
         chk("d0_key", 32'(z_out_if.key), 32'(k));
         chk("d0_data", 32'(z_out_if.data), 32'(d));
         chk("d0_hit", 32'(z_hit), 0);
         chk("d0_any", 32'(z_any), 0);
         chk("d0_count", 32'(z_count), 0);
         @(negedge clk);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
